// File: rtl/div_int.sv
// div_int: sequential restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to enable the run-time signed mode (sgn input).
module div_int #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divs;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             ge;
  logic             accept;
  logic             last;
  logic             dbz_hit;
  logic             ovf_hit;

  assign busy    = (state == RUN);
  assign accept  = (state == IDLE) && start;
  assign last    = (state == RUN) && (cnt == LAST);
  assign dbz_hit = (b == '0);

  // acc < divisor always holds, so the borrow bit alone decides ge
  assign acc_sh = {acc, quo[WIDTH-1]};
  assign diff   = acc_sh - {1'b0, divs};
  assign ge     = ~diff[WIDTH];
  assign rem_n  = ge ? diff[WIDTH-1:0] : acc_sh[WIDTH-1:0];
  assign quo_n  = {quo[WIDTH-2:0], ge};

`ifdef DIV_SIGNED_EN
  logic qneg, rneg;
  logic qneg_in, rneg_in;

  assign ovf_hit = sgn
    & (a == {1'b1, {(WIDTH-1){1'b0}}})
    & (&b);
  assign qneg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign rneg_in = sgn & a[WIDTH-1];
  assign mag_a   = rneg_in ? -a : a;
  assign mag_b   = (sgn & b[WIDTH-1]) ? -b : b;
  assign q_fin   = qneg ? -quo_n : quo_n;
  assign r_fin   = (rneg && (rem_n != '0)) ? -rem_n : rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (accept) begin
      qneg <= qneg_in;
      rneg <= rneg_in;
    end
  end
`else
  logic sgn_unused;

  assign sgn_unused = sgn;
  assign ovf_hit    = 1'b0;
  assign mag_a      = a;
  assign mag_b      = b;
  assign q_fin      = quo_n;
  assign r_fin      = rem_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start && !dbz_hit && !ovf_hit) state_n = RUN;
      RUN:  if (cnt == LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      quo   <= '0;
      divs  <= '0;
      done  <= 1'b0;
      valid <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      val   <= '0;
      rem   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        valid <= 1'b0;
        dbz   <= 1'b0;
        ovf   <= 1'b0;
        cnt   <= '0;
        if (dbz_hit) begin
          done <= 1'b1;
          dbz  <= 1'b1;
          val  <= '1;
          rem  <= a;
        end else if (ovf_hit) begin
          done <= 1'b1;
          ovf  <= 1'b1;
          val  <= a;
          rem  <= '0;
        end else begin
          acc  <= '0;
          quo  <= mag_a;
          divs <= mag_b;
        end
      end else if (state == RUN) begin
        acc <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          cnt   <= '0;
          val   <= q_fin;
          rem   <= r_fin;
          valid <= 1'b1;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_int.sv
// tb_div_int: directed vector table plus handshake corner sequences.
// Expectations follow the DIV_SIGNED_EN setting of the build.
module tb_div_int;

`ifdef DIV_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sgn = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, valid, dbz, ovf;
  logic [7:0] val, rem;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_int #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .dbz   (dbz),
    .ovf   (ovf),
    .val   (val),
    .rem   (rem)
  );

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       v;
    logic       z;
    logic       o;
    int         edges;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic s, input logic [7:0] aa,
                       input logic [7:0] bb);
    @(negedge clk);
    sgn   = s;
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int e, output int bc);
    e  = 0;
    bc = 0;
    while (!done && e < 20) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic run_vec(input vec_t t, input int i);
    int e, bc;
    issue(t.s, t.a, t.b);
    wait_done(e, bc);
    chk($sformatf("v%0d_done", i), done, 1'b1);
    chk($sformatf("v%0d_lat", i), e, t.edges);
    chk($sformatf("v%0d_busy", i), bc, t.edges);
    chk($sformatf("v%0d_q", i), val, t.q);
    chk($sformatf("v%0d_r", i), rem, t.r);
    chk($sformatf("v%0d_v", i), valid, t.v);
    chk($sformatf("v%0d_dbz", i), dbz, t.z);
    chk($sformatf("v%0d_ovf", i), ovf, t.o);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_pulse", i), done, 1'b0);
  endtask

  initial begin
    int e, bc, seen;

    tv[0]  = vec_t'{1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b1, 1'b0, 1'b0, 8};
    tv[1]  = SE ? vec_t'{1'b1, 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b1, 1'b0, 1'b0, 8}
                : vec_t'{1'b1, 8'h9C, 8'd7, 8'h16, 8'h02, 1'b1, 1'b0, 1'b0, 8};
    tv[2]  = SE ? vec_t'{1'b1, 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b1, 1'b0, 1'b0, 8}
                : vec_t'{1'b1, 8'd100, 8'hF9, 8'h00, 8'd100, 1'b1, 1'b0, 1'b0, 8};
    tv[3]  = SE ? vec_t'{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 0}
                : vec_t'{1'b1, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 8};
    tv[4]  = vec_t'{1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 8};
    tv[5]  = vec_t'{1'b0, 8'd55, 8'h00, 8'hFF, 8'd55, 1'b0, 1'b1, 1'b0, 0};
    tv[6]  = vec_t'{1'b1, 8'd55, 8'h00, 8'hFF, 8'd55, 1'b0, 1'b1, 1'b0, 0};
    tv[7]  = vec_t'{1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8};
    tv[8]  = vec_t'{1'b0, 8'd7, 8'd9, 8'h00, 8'd7, 1'b1, 1'b0, 1'b0, 8};
    tv[9]  = SE ? vec_t'{1'b1, 8'h81, 8'hFE, 8'h3F, 8'hFF, 1'b1, 1'b0, 1'b0, 8}
                : vec_t'{1'b1, 8'h81, 8'hFE, 8'h00, 8'h81, 1'b1, 1'b0, 1'b0, 8};
    tv[10] = SE ? vec_t'{1'b1, 8'h80, 8'h02, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 8}
                : vec_t'{1'b1, 8'h80, 8'h02, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 8};
    tv[11] = vec_t'{1'b1, 8'hF9, 8'hF9, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8};
    tv[12] = SE ? vec_t'{1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b1, 1'b0, 1'b0, 8}
                : vec_t'{1'b1, 8'hF9, 8'h02, 8'h7C, 8'h01, 1'b1, 1'b0, 1'b0, 8};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_flags", {dbz, ovf}, 2'b00);
    chk("rst_out", {val, rem}, 16'h0000);

    for (int i = 0; i < 13; i++) run_vec(tv[i], i);

    // start pulse during the run must be ignored
    issue(1'b0, 8'd100, 8'd7);
    repeat (2) @(posedge clk);
    issue(1'b0, 8'd9, 8'd3);
    chk("bsy_still", busy, 1'b1);
    wait_done(e, bc);
    chk("bsy_lat", e, 5);
    chk("bsy_q", val, 8'd14);
    chk("bsy_r", rem, 8'd2);
    chk("bsy_v", valid, 1'b1);

    // back-to-back start taken in the done cycle
    issue(1'b0, 8'd9, 8'd3);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_vclr", valid, 1'b0);
    chk("b2b_hold", {val, rem}, {8'd14, 8'd2});
    wait_done(e, bc);
    chk("b2b_lat", e, 8);
    chk("b2b_q", val, 8'd3);
    chk("b2b_r", rem, 8'd0);
    chk("b2b_v", valid, 1'b1);

    // reset in the middle of a run
    issue(1'b0, 8'd100, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_valid", valid, 1'b0);
    chk("mrst_out", {val, rem}, 16'h0000);
    chk("mrst_flags", {dbz, ovf}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("mrst_quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/div_int.md
# div_int

Parametrised sequential integer divider, successor to the unsigned-only restoring divider. It adds a run-time signed/unsigned mode, explicit overflow detection, and start-while-busy protection. It computes one quotient bit per clock and sits beside the datapath as a multi-cycle co-unit driven by a start/done handshake.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..64.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a division; sampled only while busy=0.
- sgn  in  1  1 = two's-complement signed operands and results; 0 = unsigned. Sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse when a request completes, including error cases.
- valid  out  1  val/rem hold a correct result. Held until the next accepted start.
- dbz  out  1  last request had b==0.
- ovf  out  1  last request was signed, with a = -2^(WIDTH-1) and b = -1.
- val  out  WIDTH  quotient.
- rem  out  WIDTH  remainder.

## Operation
- Reset: busy, done, valid, dbz and ovf go to 0; val and rem go to 0; the internal counter and state clear.
- States:
  - IDLE: accept start; go to RUN, or complete immediately on an error.
  - RUN: perform WIDTH iterations, then return to IDLE.
- Accepted start clears valid, dbz and ovf in the same edge.
- b==0 (either mode):
  - stay in IDLE; the next cycle has done=1, dbz=1, valid=0;
  - val = all ones; rem = a.
- Signed overflow (sgn=1, a=100…0, b=all ones):
  - stay in IDLE; the next cycle has done=1, ovf=1, valid=0;
  - val = a; rem = 0.
- Normal case:
  - latch |a|, |b| (magnitudes when sgn=1, raw values otherwise), the quotient sign a[MSB]^b[MSB], and the remainder sign a[MSB];
  - sign flags are forced to 0 when sgn=0.
- Iteration (restoring):
  - the accumulator is WIDTH+1 bits;
  - each RUN cycle, shift {acc,quo} left by 1 and bring in the next dividend bit;
  - if acc >= {0,|b|}, subtract and set the quotient LSB to 1, otherwise set it to 0.
- Final edge:
  - negate the quotient if the quotient sign is set;
  - negate the remainder if the remainder sign is set and the remainder is nonzero;
  - register the results to val/rem; set valid=1 and done=1; set busy=0.
- Signed semantics are truncating: a = val*b + rem, |rem| < |b|, and sign(rem) = sign(a) or rem = 0.
- start while busy=1 is ignored. The operation in flight is unaffected, and the request is not queued.

## Timing
- Start accepted at edge E0. busy=1 from E0 through E(WIDTH-1).
- At E(WIDTH): busy=0, done=1, valid=1, val and rem updated.
- Latency start→done = WIDTH cycles. Error cases take 1 cycle.
- done is high for exactly one cycle.
- A new start may be asserted in the done cycle and is accepted at that edge (back-to-back, no idle bubble).
- val/rem change only at completion edges, including error completions.
- rst asserted mid-operation: all outputs immediately return to their reset values, and no done pulse is produced.
- Iteration counter width is $clog2(WIDTH+1); it must not wrap before WIDTH is reached.

## Configuration
- DIV_SIGNED_EN defined: signed mode is implemented as above.
- DIV_SIGNED_EN undefined:
  - sgn is ignored and treated as 0;
  - ovf is tied to 0;
  - the magnitude/negation logic is removed;
  - the block behaves as a pure unsigned divider with identical latency and handshake.

## Test plan
- Test plan values use WIDTH=8.
- Unsigned: a=100, b=7, sgn=0 → done 8 cycles after start; val=14, rem=2, valid=1, busy high for exactly 8 cycles.
- Signed: a=0x9C (-100), b=7, sgn=1 → val=0xF2 (-14), rem=0xFE (-2). Also a=100, b=0xF9 (-7) → val=0xF2, rem=2.
- Errors:
  - a=0x80, b=0xFF, sgn=1 → 1 cycle later done=1, ovf=1, valid=0, val=0x80, rem=0;
  - a=0x80, b=0xFF, sgn=0 → val=0, rem=0x80, valid=1 after 8 cycles.
- Divide by zero: a=55, b=0 → done next cycle with dbz=1, valid=0, val=0xFF, rem=55.
- Start while busy: a new start pulse with a=9, b=3 at cycle 3 of a=100/7 → result remains 14 r 2. A start in the done cycle yields 3 r 0, 8 cycles later.
- Reset mid-run: assert rst during cycle 4 → busy, done, valid and val/rem are 0 immediately, and no done pulse follows.
